// File: rtl/reg_file.sv
// RV32 integer register file: x0 hardwired to zero, two combinational read ports, one write port.
// Optional write-to-read forwarding (BYPASS). Optional async clear of x1..x31 on reset (RESET_ALL).
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   read_reg1, read_reg2  source indices for operand A / operand B
//   write_reg, write_data destination index and writeback value
//   reg_write             write enable for the current cycle
//   read_data1/2          operand A / operand B values
module reg_file #(
  parameter bit BYPASS    = 1'b1,
  parameter bit RESET_ALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        reg_write,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  logic [31:0] regs [31:1];

  logic wr_en;
  logic zero1;
  logic zero2;
  logic fwd1;
  logic fwd2;

  // A write is live only out of reset and never to x0.
  assign wr_en = reg_write && (write_reg != 5'd0) && rst_n;

  generate
    if (RESET_ALL) begin : g_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
          end
        end else if (wr_en) begin
          regs[write_reg] <= write_data;
        end
      end
    end else begin : g_keep
      // Contents survive reset; reset only blocks the write.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          regs[write_reg] <= write_data;
        end
      end
    end
  endgenerate

  assign zero1 = (read_reg1 == 5'd0);
  assign zero2 = (read_reg2 == 5'd0);
  assign fwd1  = BYPASS && wr_en && (read_reg1 == write_reg);
  assign fwd2  = BYPASS && wr_en && (read_reg2 == write_reg);

  // zero and fwd are exclusive: fwd implies a nonzero index.
  always_comb begin
    read_data1 = '0;
    unique case (1'b1)
      zero1:   read_data1 = '0;
      fwd1:    read_data1 = write_data;
      default: read_data1 = regs[read_reg1];
    endcase
  end

  always_comb begin
    read_data2 = '0;
    unique case (1'b1)
      zero2:   read_data2 = '0;
      fwd2:    read_data2 = write_data;
      default: read_data2 = regs[read_reg2];
    endcase
  end

endmodule
